// File: rtl/ir_wand_transmitter.sv
// ir_wand_transmitter: sends a 16-bit code as a pulse-distance IR frame
// (leader, 16 MSB-first data bits, stop mark, gap) on a gated carrier.
module ir_wand_transmitter #(
   parameter int CARRIER_HALF = 658,
   parameter int LEAD_MARK    = 342,
   parameter int LEAD_SPACE   = 171,
   parameter int BIT_MARK     = 21,
   parameter int ZERO_SPACE   = 21,
   parameter int ONE_SPACE    = 64,
   parameter int GAP          = 1520
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] code_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        ir_out,
   output logic        envelope,
   output logic        busy,
   output logic        tx_done
);
   localparam int CW = $clog2(CARRIER_HALF + 1);
   typedef enum logic [2:0] {IDLE, LEAD_M, LEAD_S, BIT_M, BIT_S, STOP_M, GAP_S} state_t;
   state_t state_q, state_d;
   logic [15:0]   sh_q, tick_q, dur;
   logic [4:0]    bit_q;
   logic [CW-1:0] cnt_q;
   logic          phase_q, done_q, half_end, period_end, last;
   assign dur = state_q == LEAD_M ? 16'(LEAD_MARK) :
                state_q == LEAD_S ? 16'(LEAD_SPACE) :
                state_q == BIT_S  ? (sh_q[15] ? 16'(ONE_SPACE) : 16'(ZERO_SPACE)) :
                state_q == GAP_S  ? 16'(GAP) : 16'(BIT_MARK);
   assign half_end   = cnt_q == CW'(CARRIER_HALF - 1);
   // phase starts high, so a full carrier period ends on the wrap of the low half
   assign period_end = half_end && !phase_q;
   assign last       = period_end && tick_q == dur - 16'd1;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = in_valid ? LEAD_M : IDLE;
         LEAD_M:  state_d = last ? LEAD_S : LEAD_M;
         LEAD_S:  state_d = last ? BIT_M : LEAD_S;
         BIT_M:   state_d = last ? BIT_S : BIT_M;
         BIT_S:   state_d = last ? (bit_q == 5'd15 ? STOP_M : BIT_M) : BIT_S;
         STOP_M:  state_d = last ? GAP_S : STOP_M;
         GAP_S:   state_d = last ? IDLE : GAP_S;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= state_q == STOP_M && state_d == GAP_S;
         if (state_d != state_q) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
            tick_q  <= '0;
         end else if (state_q != IDLE) begin
            cnt_q   <= half_end ? '0 : cnt_q + CW'(1);
            phase_q <= half_end ? !phase_q : phase_q;
            tick_q  <= period_end ? tick_q + 16'd1 : tick_q;
         end
         if (state_q == IDLE && in_valid) begin
            sh_q  <= code_in;
            bit_q <= '0;
         end else if (state_q == BIT_S && last) begin
            sh_q  <= {sh_q[14:0], 1'b0};
            bit_q <= bit_q + 5'd1;
         end
      end
   end
   assign envelope = state_q == LEAD_M || state_q == BIT_M || state_q == STOP_M;
   assign ir_out   = envelope && phase_q;
   assign in_ready = state_q == IDLE;
   assign busy     = !in_ready;
   assign tx_done  = done_q;
endmodule

// File: tb/tb_ir_wand_transmitter.sv
// tb_ir_wand_transmitter: table of frames plus back-to-back and mid-frame
// reset sequences; expected codes and tx_done cycles go through a queue.
module tb_ir_wand_transmitter;
   logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0;
   logic [15:0] code_in = '0;
   logic        in_ready, ir_out, envelope, busy, tx_done;
   int          vecs = 0, miss = 0, cyc = 0;
   typedef struct {logic [15:0] code; int exp;} vec_t;
   vec_t vt[5];
   vec_t sb[$];
   ir_wand_transmitter #(.CARRIER_HALF(2), .LEAD_MARK(4), .LEAD_SPACE(2), .BIT_MARK(1),
      .ZERO_SPACE(1), .ONE_SPACE(3), .GAP(2)) dut (
      .clock(clock), .reset(reset), .code_in(code_in), .in_valid(in_valid),
      .in_ready(in_ready), .ir_out(ir_out), .envelope(envelope), .busy(busy), .tx_done(tx_done));
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end
   task automatic check(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask
   task automatic frame(input logic [15:0] code, input int exp, input bit hold,
                        input logic [15:0] nxt, input int rst_at,
                        output int lead_abs, output int done_abs);
      int n = 0, sp = 0, nsp = 0, done_c = -1, carr_err = 0, busy_err = 0, sp_err = 0, nd = 0;
      bit prev = 1'b0;
      logic [15:0] bits = '0;
      vec_t e;
      lead_abs = 0;
      done_abs = 0;
      while (!in_ready && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check("ready_wait", int'(in_ready), 1);
      code_in  = code;
      in_valid = 1'b1;
      sb.push_back('{code, exp});
      for (int c = 1; c <= 400; c++) begin
         @(negedge clock);
         if (c == 1) begin
            if (hold) code_in = nxt;
            else in_valid = 1'b0;
            lead_abs = cyc;
            check("accept_out", int'({ir_out, envelope, busy, in_ready}), 4'b1110);
         end
         if (rst_at != 0 && c == rst_at + 1) begin
            reset = 1'b0;
            check("rst_out", int'({ir_out, envelope, busy, in_ready, tx_done}), 5'b00010);
            if (sb.size() > 0) void'(sb.pop_front());
            for (int k = 0; k < 300; k++) begin
               @(negedge clock);
               nd += int'(tx_done);
            end
            check("no_done_after_rst", nd, 0);
            return;
         end
         if (rst_at == c) reset = 1'b1;
         if (c <= 16 && ir_out != ((c - 1) % 4 < 2)) carr_err++;
         if (busy == in_ready) busy_err++;
         if (!envelope) sp = prev ? 1 : sp + 1;
         if (!prev && envelope && c > 1) begin
            if (nsp == 0) sp_err += int'(sp != 8);
            else begin
               sp_err += int'(sp != 4 && sp != 12);
               bits = {bits[14:0], sp == 12};
            end
            nsp++;
         end
         prev = envelope;
         if (tx_done) begin
            done_c   = c;
            done_abs = cyc;
            break;
         end
      end
      if (sb.size() == 0) begin
         check("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      check("done_cycle", done_c, e.exp);
      check("bits", int'(bits), int'(e.code));
      check("spaces", sp_err + int'(nsp != 17), 0);
      check("carrier", carr_err, 0);
      check("busy_inv", busy_err, 0);
      if (done_c < 0) return;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         if (k == 1) check("done_width", int'(tx_done), 0);
         if (k == 7) check("ready_in_gap", int'(in_ready), 0);
         if (k == 8) check("ready_after_gap", int'({in_ready, envelope}), 2'b10);
      end
   endtask
   initial begin
      int l1, d1, l2, d2;
      vt[0] = '{16'h0000, 157};
      vt[1] = '{16'hFFFF, 285};
      vt[2] = '{16'hA5A5, 221};
      vt[3] = '{16'h8001, 173};
      vt[4] = '{16'h7FFE, 269};
      in_valid = 1'b1;
      code_in  = 16'hFFFF;
      repeat (3) @(negedge clock);
      check("reset_state", int'({in_ready, ir_out, busy, envelope, tx_done}), 5'b10000);
      reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check("reset_no_accept", int'({in_ready, busy, envelope}), 3'b100);
      foreach (vt[i]) frame(vt[i].code, vt[i].exp, 1'b0, 16'h0, 0, l1, d1);
      frame(16'h1234, 197, 1'b1, 16'h00FF, 0, l1, d1);
      frame(16'h00FF, 221, 1'b0, 16'h0, 0, l2, d2);
      check("b2b_leader_gap", l2 - d1, 9);
      frame(16'hFFFF, 285, 1'b0, 16'h0, 50, l1, d1);
      frame(16'hFFFF, 285, 1'b0, 16'h0, 0, l1, d1);
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
